// File: rtl/burst_ram_pkg.sv
// ---------------------------------------------------------------------------
// burst_ram_pkg
// Shared constants for the BurstRAM client/arbiter family: arbiter state
// encodings, command encodings and the beat/mask widths of a BurstRAM port.
// No ports; imported by burst_ram_arbiter.
// ---------------------------------------------------------------------------
package burst_ram_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } arb_st_e;

  localparam logic CMD_READ  = 1'b0;
  localparam logic CMD_WRITE = 1'b1;

  localparam int BEAT_W = 64;
  localparam int MASK_W = 8;

endpackage

// File: rtl/burst_ram_arbiter.sv
// ---------------------------------------------------------------------------
// burst_ram_arbiter
// Two-client arbiter in front of a single BurstRAM. Each client keeps an
// unchanged BurstRAM-style port. Whole bursts are granted round-robin; the
// command, address, write data and mask are muxed to the RAM, and read beats
// are steered back to the client that owns the current burst.
//
// Ports
//   clk, rst                  system clock, synchronous active-high reset
//   cN_cmd                    in   0 = read, 1 = write
//   cN_cmd_en                 in   command/address valid (only while !cN_busy)
//   cN_addr                   in   burst start address
//   cN_wr_data, cN_data_mask  in   write beat and its byte mask
//   cN_rd_data                out  read beat (broadcast to both clients)
//   cN_rd_data_valid          out  read beat valid, owner only
//   cN_busy                   out  client must not issue a command
//   br_cmd .. br_data_mask    out  command side towards BurstRAM
//   br_rd_data(_valid), br_busy in response side from BurstRAM
// ---------------------------------------------------------------------------
module burst_ram_arbiter
  import burst_ram_pkg::*;
#(
  parameter int DEPTH_BITWIDTH = 4,
  parameter int BURST_COUNT    = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  // client 0
  input  logic                      c0_cmd,
  input  logic                      c0_cmd_en,
  input  logic [DEPTH_BITWIDTH-1:0] c0_addr,
  input  logic [BEAT_W-1:0]         c0_wr_data,
  input  logic [MASK_W-1:0]         c0_data_mask,
  output logic [BEAT_W-1:0]         c0_rd_data,
  output logic                      c0_rd_data_valid,
  output logic                      c0_busy,
  // client 1
  input  logic                      c1_cmd,
  input  logic                      c1_cmd_en,
  input  logic [DEPTH_BITWIDTH-1:0] c1_addr,
  input  logic [BEAT_W-1:0]         c1_wr_data,
  input  logic [MASK_W-1:0]         c1_data_mask,
  output logic [BEAT_W-1:0]         c1_rd_data,
  output logic                      c1_rd_data_valid,
  output logic                      c1_busy,
  // BurstRAM side
  output logic                      br_cmd,
  output logic                      br_cmd_en,
  output logic [DEPTH_BITWIDTH-1:0] br_addr,
  output logic [BEAT_W-1:0]         br_wr_data,
  output logic [MASK_W-1:0]         br_data_mask,
  input  logic [BEAT_W-1:0]         br_rd_data,
  input  logic                      br_rd_data_valid,
  input  logic                      br_busy
);

  // A 1-bit counter is still needed when BURST_COUNT == 2.
  localparam int CNT_W = (BURST_COUNT > 2) ? $clog2(BURST_COUNT) : 1;
  // Reads count every beat; writes count only beats 1..BURST_COUNT-1, since
  // beat 0 travels with cmd_en.
  localparam logic [CNT_W-1:0] CNT_LAST_RD = CNT_W'(BURST_COUNT - 1);
  localparam logic [CNT_W-1:0] CNT_LAST_WR = CNT_W'(BURST_COUNT - 2);

  arb_st_e          r_st, w_st_nxt;
  logic             r_owner, w_owner_nxt;
  logic             r_offer, w_offer_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;

  logic             w_sel;
  logic             w_cmd;
  logic             w_cmd_en_sel;
  logic             w_fwd;
  logic             w_busy0, w_busy1;
  logic             w_vld0, w_vld1;

  // In IDLE the offered client drives the command bus so cmd_en can be
  // forwarded in the same cycle; during a burst the owner drives it.
  assign w_sel        = (r_st == IDLE) ? r_offer : r_owner;
  assign w_cmd        = w_sel ? c1_cmd : c0_cmd;
  assign w_cmd_en_sel = r_offer ? c1_cmd_en : c0_cmd_en;

  assign br_cmd       = w_cmd;
  assign br_addr      = w_sel ? c1_addr      : c0_addr;
  assign br_wr_data   = w_sel ? c1_wr_data   : c0_wr_data;
  assign br_data_mask = w_sel ? c1_data_mask : c0_data_mask;
  assign br_cmd_en    = w_fwd;

  assign c0_rd_data       = br_rd_data;
  assign c1_rd_data       = br_rd_data;
  assign c0_rd_data_valid = w_vld0;
  assign c1_rd_data_valid = w_vld1;
  assign c0_busy          = w_busy0;
  assign c1_busy          = w_busy1;

  always_comb begin
    w_st_nxt    = r_st;
    w_owner_nxt = r_owner;
    w_offer_nxt = r_offer;
    w_cnt_nxt   = r_cnt;
    w_fwd       = 1'b0;
    w_busy0     = 1'b1;
    w_busy1     = 1'b1;
    w_vld0      = 1'b0;
    w_vld1      = 1'b0;

    unique case (r_st)
      IDLE: begin
        w_busy0 = br_busy | r_offer;
        w_busy1 = br_busy | ~r_offer;
        w_fwd   = w_cmd_en_sel & ~br_busy;
        if (w_fwd) begin
          w_owner_nxt = r_offer;
          w_cnt_nxt   = '0;
          w_st_nxt    = (w_cmd == CMD_WRITE) ? WRITE : READ;
        end else if (!br_busy) begin
          // Idle offer alternates so either client waits at most one cycle;
          // it freezes while the RAM is busy (refresh/init).
          w_offer_nxt = ~r_offer;
        end
      end

      READ: begin
        w_vld0 = br_rd_data_valid & ~r_owner;
        w_vld1 = br_rd_data_valid & r_owner;
        if (br_rd_data_valid) begin
          if (r_cnt == CNT_LAST_RD) begin
            w_st_nxt    = IDLE;
            w_offer_nxt = ~r_owner;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end

      WRITE: begin
        // Owner delivers one beat per cycle, no handshake.
        if (r_cnt == CNT_LAST_WR) begin
          w_st_nxt    = IDLE;
          w_offer_nxt = ~r_owner;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end

      default: w_st_nxt = IDLE;
    endcase

    if (rst) begin
      w_fwd   = 1'b0;
      w_busy0 = 1'b1;
      w_busy1 = 1'b1;
      w_vld0  = 1'b0;
      w_vld1  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_st    <= IDLE;
      r_owner <= 1'b0;
      r_offer <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_st    <= w_st_nxt;
      r_owner <= w_owner_nxt;
      r_offer <= w_offer_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

endmodule
